// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared definitions for the register write-back queue.
//
// Contents:
//   REG_ADDR_W  register-number width (5)
//   DATA_W      result width (32)
//   wb_entry_t  one pending write: {regno, data}
//
// The register-number field is called regno because "reg" is a reserved word.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regno;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Register 0 is hard-wired; writes to it are never queued.
    function automatic logic is_wb_target(input logic [REG_ADDR_W-1:0] r);
        return r != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo -- storage and pointers for pending register writes.
//
// Parameters:
//   DEPTH        number of entries (power of two, >= 2)
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset (pointers/count only)
//   push         write push_entry at the tail (caller guarantees !full)
//   push_entry   entry to enqueue
//   pop          drop the head entry (caller guarantees count != 0)
//   head         oldest queued entry
//   count        number of queued entries
//   full         count == DEPTH
//   entries      raw storage, for the forwarding search
//                (only with REG_WRITEBACK_QUEUE_BYPASS_EN)
//   rd_ptr_o     read pointer, for the forwarding search
//                (only with REG_WRITEBACK_QUEUE_BYPASS_EN)
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    ,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [PTR_W-1:0]      rd_ptr_o
`endif
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is deliberately not reset; only count decides what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    assign entries  = mem;
    assign rd_ptr_o = rd_ptr;
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue -- buffers execution results and retires them to the
// register-file write port one per cycle, in acceptance order.
//
// Optional feature macro: REG_WRITEBACK_QUEUE_BYPASS_EN
//   When defined, adds a combinational forwarding search of the queue and the
//   output stage for two read addresses.
//
// Parameters:
//   DEPTH        pending-entry capacity (power of two, >= 2)
// Ports:
//   clock        sole clock, rising edge
//   reset_n      synchronous active-low reset
//   in_valid     producer has a result
//   in_ready     queue has room (from registered count only)
//   in_reg       destination register; 0 is accepted and dropped
//   in_data      result value
//   drain_hold   stall issue to the register file
//   Writereg     registered write address
//   Writedata    registered write data
//   RegWrite     registered write strobe, high for one cycle per write
//   Readreg1/2   register-file read addresses
//   count        queued entries
//   fwd_hit1/2   forwarding hit      (only with REG_WRITEBACK_QUEUE_BYPASS_EN)
//   fwd_data1/2  forwarded value     (only with REG_WRITEBACK_QUEUE_BYPASS_EN)
// -----------------------------------------------------------------------------
module reg_writeback_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_reg,
    input  logic [31:0]      in_data,
    input  logic             drain_hold,
    output logic [4:0]       Writereg,
    output logic [31:0]      Writedata,
    output logic             RegWrite,
    input  logic [4:0]       Readreg1,
    input  logic [4:0]       Readreg2,
    output logic [CNT_W-1:0] count
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    ,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [31:0]      fwd_data1,
    output logic [31:0]      fwd_data2
`endif
);

    wb_entry_t push_entry;
    wb_entry_t head;
    logic      full;
    logic      accept;
    logic      push;
    logic      pop;

    // A full queue refuses input even if it pops this cycle: in_ready must
    // not depend on drain_hold.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_wb_target(in_reg);
    assign pop      = (count != '0) && !drain_hold;

    assign push_entry.regno = in_reg;
    assign push_entry.data  = in_data;

`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] fifo_entries;
    logic [PTR_W-1:0]      fifo_rd_ptr;
`endif

    wb_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full)
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
        ,
        .entries    (fifo_entries),
        .rd_ptr_o   (fifo_rd_ptr)
`endif
    );

    // Output stage: address/data only move on a pop so the port holds its
    // last value while RegWrite is low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            Writereg  <= '0;
            Writedata <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                Writereg  <= head.regno;
                Writedata <= head.data;
            end
        end
    end

`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    logic [1:0][REG_ADDR_W-1:0] rd_addr;
    logic [1:0]                 hit;
    logic [1:0][DATA_W-1:0]     fdata;

    assign rd_addr = {Readreg2, Readreg1};

    // Search order sets priority: output stage first, then queue slots from
    // oldest to youngest, so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = '0;
        hit   = '0;
        fdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd_addr[p] != '0) begin
                if (RegWrite && (Writereg == rd_addr[p])) begin
                    hit[p]   = 1'b1;
                    fdata[p] = Writedata;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = fifo_rd_ptr + PTR_W'(i);
                    if ((CNT_W'(i) < count) && (fifo_entries[idx].regno == rd_addr[p])) begin
                        hit[p]   = 1'b1;
                        fdata[p] = fifo_entries[idx].data;
                    end
                end
            end
        end
    end

    assign fwd_hit1  = hit[0];
    assign fwd_hit2  = hit[1];
    assign fwd_data1 = fdata[0];
    assign fwd_data2 = fdata[1];
`else
    // Read addresses only feed the forwarding search.
    logic unused_rd;
    assign unused_rd = &{1'b0, Readreg1, Readreg2};
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_queue -- scoreboard bench for reg_writeback_queue.
// Driver issues stimulus and updates a queue-based reference model at each
// rising edge; a separate monitor checks DUT outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          drain_hold;
    logic [4:0]    Writereg;
    logic [31:0]   Writedata;
    logic          RegWrite;
    logic [4:0]    Readreg1;
    logic [4:0]    Readreg2;
    logic [CW-1:0] count;
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    logic          fwd_hit1, fwd_hit2;
    logic [31:0]   fwd_data1, fwd_data2;
`endif

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .drain_hold (drain_hold),
        .Writereg   (Writereg),
        .Writedata  (Writedata),
        .RegWrite   (RegWrite),
        .Readreg1   (Readreg1),
        .Readreg2   (Readreg2),
        .count      (count)
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
        ,
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mpend[$];   // model: entries waiting in the queue
    ent_t        expq[$];    // scoreboard: writes expected on the port, in order
    bit          mrw;        // model: RegWrite this cycle
    logic [4:0]  mwreg;
    logic [31:0] mwdata;
    bit          armed = 0;
    bit          done  = 0;
    int          total  = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; the model applies the queue rules at the edge.
    task automatic step(input bit rst, input bit v, input logic [4:0] r,
                        input logic [31:0] d, input bit hold,
                        input logic [4:0] a1, input logic [4:0] a2);
        bit   pop, acc;
        ent_t e;
        reset_n    = !rst;
        in_valid   = v;
        in_reg     = r;
        in_data    = d;
        drain_hold = hold;
        Readreg1   = a1;
        Readreg2   = a2;
        @(posedge clock);
        if (rst) begin
            mpend.delete();
            expq.delete();
            mrw    = 0;
            mwreg  = '0;
            mwdata = '0;
        end else begin
            pop = (mpend.size() > 0) && !hold;
            acc = v && (mpend.size() < DEPTH);
            mrw = pop;
            if (pop) begin
                e      = mpend.pop_front();
                mwreg  = e.r;
                mwdata = e.d;
            end
            if (acc && r != 0) begin
                e.r = r;
                e.d = d;
                mpend.push_back(e);
                expq.push_back(e);
            end
        end
        armed = 1;
        #1;
    endtask

    task automatic idle(input int n, input bit hold, input logic [4:0] a1, input logic [4:0] a2);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, hold, a1, a2);
    endtask

`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    // Expected {hit, data}: later matches override earlier ones.
    function automatic logic [32:0] fwd_model(input logic [4:0] a);
        logic [32:0] res;
        res = '0;
        if (a == 0) return res;
        if (mrw && mwreg == a) res = {1'b1, mwdata};
        foreach (mpend[i]) if (mpend[i].r == a) res = {1'b1, mpend[i].d};
        return res;
    endfunction
`endif

    // Monitor
    initial begin : mon
        ent_t        e;
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
        logic [32:0] f;
`endif
        forever begin
            @(negedge clock);
            if (armed && !done) begin
                chk("count", 32'(count), 32'(mpend.size()));
                chk("in_ready", 32'(in_ready), 32'(mpend.size() < DEPTH));
                chk("RegWrite", 32'(RegWrite), 32'(mrw));
                if (RegWrite === 1'b1) begin
                    if (expq.size() == 0) begin
                        chk("write_unexpected", 32'(Writereg), 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        chk("Writereg", 32'(Writereg), 32'(e.r));
                        chk("Writedata", Writedata, e.d);
                    end
                end else begin
                    chk("Writereg_hold", 32'(Writereg), 32'(mwreg));
                    chk("Writedata_hold", Writedata, mwdata);
                end
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
                f = fwd_model(Readreg1);
                chk("fwd_hit1", 32'(fwd_hit1), 32'(f[32]));
                chk("fwd_data1", fwd_data1, f[31:0]);
                f = fwd_model(Readreg2);
                chk("fwd_hit2", 32'(fwd_hit2), 32'(f[32]));
                chk("fwd_data2", fwd_data2, f[31:0]);
`endif
            end
        end
    end

    // Driver
    initial begin : drv
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);

        // Single result into an empty queue: write two cycles later, once.
        step(0, 1, 5'd5, 32'h0000_00AA, 0, 5'd5, 5'd0);
        idle(4, 0, 5'd5, 5'd0);

        // Fill under hold, try one more (refused), then drain in order.
        for (int i = 0; i < 4; i++) step(0, 1, 5'(i + 1), 32'h100 + 32'(i), 1, 5'd1, 5'd3);
        step(0, 1, 5'd9, 32'h999, 1, 5'd9, 5'd2);
        idle(6, 0, 5'd2, 5'd4);

        // Register 0 is accepted and dropped.
        step(0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0);
        idle(3, 0, 5'd0, 5'd0);

        // Reset with three entries pending.
        for (int i = 0; i < 3; i++) step(0, 1, 5'(i + 10), 32'h200 + 32'(i), 1, 5'd10, 5'd11);
        step(1, 0, 5'd0, 32'd0, 0, 5'd10, 5'd11);
        idle(4, 0, 5'd10, 5'd11);

        // Two writes to the same register: youngest forwards.
        step(0, 1, 5'd7, 32'h11, 1, 5'd7, 5'd0);
        step(0, 1, 5'd7, 32'h22, 1, 5'd7, 5'd0);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd0);
        idle(4, 0, 5'd7, 5'd0);

        // Full queue with pop and in_valid, then 3*DEPTH streaming transfers.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 5'(i + 20), 32'h300 + 32'(i), 1, 5'd20, 5'd23);
        step(0, 1, 5'd3, 32'h333, 0, 5'd3, 5'd21);
        for (int i = 0; i < 3 * DEPTH; i++)
            step(0, 1, 5'((i % 31) + 1), 32'h400 + 32'(i), 0, 5'((i % 31) + 1), 5'd21);
        idle(6, 0, 5'd1, 5'd2);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(8, 0, 5'd0, 5'd0);

        done = 1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of pending write entries; power of two, >= 2.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 SHALL have port: in_valid  input  1  producer presents a result.
REQ-005 SHALL have port: in_ready  output  1  queue can accept a result this cycle.
REQ-006 SHALL have port: in_reg  input  5  destination register number.
REQ-007 SHALL have port: in_data  input  32  result value.
REQ-008 SHALL have port: drain_hold  input  1  when 1, no new write is issued to the register file.
REQ-009 SHALL have ports: Writereg  output  5; Writedata  output  32; RegWrite  output  1; all registered, driving the register-file write port.
REQ-010 SHALL have ports: Readreg1, Readreg2  input  5  read addresses presented to the register file.
REQ-011 SHALL have port: count  output  $clog2(DEPTH+1)  number of queued entries.

Function
REQ-012 SHALL accept a result when in_valid && in_ready at a rising edge; in_ready = (count < DEPTH), registered-state-derived, no full-pass-through.
REQ-013 SHALL discard an accepted result with in_reg == 0: handshake completes, nothing enqueued, count unchanged.
REQ-014 SHALL pop the head entry when count > 0 && !drain_hold, loading Writereg/Writedata from it and setting RegWrite = 1 at the same edge.
REQ-015 SHALL set RegWrite = 0 at any edge where no pop occurs; Writereg/Writedata hold their previous values.
REQ-016 SHALL issue writes in acceptance order (FIFO), one per cycle maximum.
REQ-017 SHALL give latency: result accepted in cycle c, queue empty, drain_hold = 0 -> RegWrite = 1 with that entry in cycle c+2.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged; full with pop still deasserts in_ready that cycle.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL keep queue contents and count frozen (except pushes) while drain_hold = 1.

Reset
REQ-021 SHALL, when reset_n = 0 at a rising edge: count = 0, pointers = 0, RegWrite = 0, Writereg = 0, Writedata = 0.
REQ-022 SHALL discard all pending entries on reset mid-operation; in_ready = 1 in the cycle after reset deasserts.
REQ-023 SHALL leave queue storage uninitialised by reset.

Configuration
REQ-024 SHALL compile the forwarding feature in only when macro REG_WRITEBACK_QUEUE_BYPASS_EN is defined.
REQ-025 SHALL, with the macro defined, add outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (32), combinational from Readreg1/Readreg2.
REQ-026 SHALL set fwd_hitN = 1 when ReadregN != 0 matches any queued entry or the current output stage (RegWrite = 1 and Writereg match); fwd_dataN = youngest match, priority youngest queued > oldest queued > output stage.
REQ-027 SHALL, with ReadregN == 0 or no match, drive fwd_hitN = 0 and fwd_dataN = 0.
REQ-028 SHALL, without the macro, omit those ports and all comparison logic.

Structure
REQ-029 SHALL place REG_ADDR_W = 5, DATA_W = 32 and typedef wb_entry_t {reg, data} in shared package wb_pkg.
REQ-030 SHALL implement storage/pointers in sub-module wb_fifo, with forwarding search in the top level.

Verification
REQ-031 SHALL cover: push (5, 0x0000_00AA) into empty queue -> RegWrite = 1, Writereg = 5, Writedata = 0xAA two cycles later, one cycle only.
REQ-032 SHALL cover: drain_hold = 1, push 4 entries -> count = 4, in_ready = 0; release -> four writes in order on four consecutive cycles.
REQ-033 SHALL cover: push in_reg = 0 with 0xDEAD -> in_ready seen, count stays 0, RegWrite never asserts.
REQ-034 SHALL cover: reset_n = 0 for one cycle with 3 entries pending -> count = 0, RegWrite = 0 next cycle, no stale writes after.
REQ-035 SHALL cover, with BYPASS_EN: queue (7, 0x11) then (7, 0x22), Readreg1 = 7 -> fwd_hit1 = 1, fwd_data1 = 0x22; Readreg2 = 0 -> fwd_hit2 = 0.
REQ-036 SHALL cover: full queue with simultaneous pop and in_valid -> no acceptance that cycle, count = DEPTH-1 after, pointer wrap verified over 3*DEPTH transfers.
